// File: rtl/triangle_scheduler.sv
// rtl/triangle_scheduler.sv - triangle command FIFO, engine issue FSM, screen clear sweep and VGA pixel mux
// Optional zero-area triangle culling: define TRI_SCHED_CULL_EN.
module triangle_scheduler #(
    parameter int         DEPTH        = 4,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        tri_valid,
    output logic        tri_ready,
    input  logic [50:0] tri_data,
    input  logic        clear_req,
    output logic [50:0] eng_data,
    output logic        eng_draw_en,
    input  logic        eng_done,
    input  logic [7:0]  eng_x,
    input  logic [7:0]  eng_y,
    input  logic [2:0]  eng_colour,
    input  logic        eng_plot,
    output logic [7:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        frame_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_ARM,
        S_DRAW
    } state_t;

    state_t             state_q, state_d;
    logic [50:0]        mem_q [DEPTH];
    logic [50:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               clear_pending_q, clear_pending_d;
    logic [50:0]        eng_data_q, eng_data_d;
    logic [7:0]         clr_x_q, clr_x_d;
    logic [7:0]         clr_y_q, clr_y_d;

    logic               push;
    logic               pop;
    logic               exit_to_idle;
    logic               fifo_empty;
    logic [50:0]        head;
    logic               cull;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign tri_ready  = (count_q != CNT_W'(DEPTH));
    assign push       = tri_valid & tri_ready;

`ifdef TRI_SCHED_CULL_EN
    // Twice the signed area; zero means the three vertices are collinear.
    logic signed [16:0] d_bax, d_cay, d_bay, d_cax;
    logic signed [33:0] area2;

    assign d_bax = $signed({9'd0, head[31:24]}) - $signed({9'd0, head[47:40]});
    assign d_cay = $signed({9'd0, head[7:0]})   - $signed({9'd0, head[39:32]});
    assign d_bay = $signed({9'd0, head[23:16]}) - $signed({9'd0, head[39:32]});
    assign d_cax = $signed({9'd0, head[15:8]})  - $signed({9'd0, head[47:40]});
    assign area2 = (d_bax * d_cay) - (d_bay * d_cax);
    assign cull  = (area2 == '0);
`else
    assign cull = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        clear_pending_d = clear_pending_q | clear_req;
        eng_data_d      = eng_data_q;
        clr_x_d         = clr_x_q;
        clr_y_d         = clr_y_q;
        pop             = 1'b0;
        eng_draw_en     = 1'b0;
        exit_to_idle    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (clear_pending_q) begin
                    state_d         = S_CLEAR;
                    clear_pending_d = 1'b0;
                    clr_x_d         = '0;
                    clr_y_d         = '0;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!cull) begin
                        eng_data_d = head;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_x_q == 8'(SCREEN_W - 1)) begin
                    clr_x_d = '0;
                    if (clr_y_q == 8'(SCREEN_H - 1)) begin
                        clr_y_d      = '0;
                        state_d      = S_IDLE;
                        exit_to_idle = 1'b1;
                    end else begin
                        clr_y_d = clr_y_q + 8'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 8'd1;
                end
            end
            S_ISSUE: begin
                if (eng_done) begin
                    eng_draw_en = 1'b1;
                    state_d     = S_ARM;
                end
            end
            S_ARM: begin
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (eng_done) begin
                    state_d      = S_IDLE;
                    exit_to_idle = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = tri_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            clear_pending_q <= 1'b0;
            eng_data_q      <= '0;
            clr_x_q         <= '0;
            clr_y_q         <= '0;
        end else begin
            state_q         <= state_d;
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            clear_pending_q <= clear_pending_d;
            eng_data_q      <= eng_data_d;
            clr_x_q         <= clr_x_d;
            clr_y_q         <= clr_y_d;
        end
    end

    // The clear sweep owns the pixel port; the engine may only write while drawing.
    always_comb begin
        if (state_q == S_CLEAR) begin
            vga_x      = clr_x_q;
            vga_y      = clr_y_q;
            vga_colour = CLEAR_COLOUR;
            vga_plot   = 1'b1;
        end else begin
            vga_x      = eng_x;
            vga_y      = eng_y;
            vga_colour = eng_colour;
            vga_plot   = eng_plot & (state_q == S_DRAW);
        end
    end

    assign eng_data   = eng_data_q;
    assign busy       = (state_q != S_IDLE) | !fifo_empty | clear_pending_q;
    assign frame_done = exit_to_idle & fifo_empty & !push & !clear_pending_q;

endmodule

// File: tb/tb_triangle_scheduler.sv
// tb/tb_triangle_scheduler.sv - scoreboard bench for triangle_scheduler with a behavioural draw engine
module tb_triangle_scheduler;

    localparam int W   = 160;
    localparam int H   = 120;
    localparam int LEN = 12;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [50:0] tri_data = '0;
    logic        clear_req = 1'b0;
    logic [50:0] eng_data;
    logic        eng_draw_en;
    logic        eng_done = 1'b1;
    logic [7:0]  eng_x = '0;
    logic [7:0]  eng_y = '0;
    logic [2:0]  eng_colour = '0;
    logic        eng_plot = 1'b0;
    logic [7:0]  vga_x, vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy, frame_done;

    triangle_scheduler dut (
        .clock(clock), .resetn(resetn),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
        .clear_req(clear_req),
        .eng_data(eng_data), .eng_draw_en(eng_draw_en), .eng_done(eng_done),
        .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour), .eng_plot(eng_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        is_clear;
        logic [50:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;
    int          hold_err = 0;
    int          px_cnt = 0;
    int          exp_draws = 0;
    bit          abort_clear = 0;
    int          abort_n = 0;
    logic [50:0] cur_data = '0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [50:0] mk(input logic [2:0] c, input logic [7:0] ax, input logic [7:0] ay,
                                       input logic [7:0] bx, input logic [7:0] by,
                                       input logic [7:0] cx, input logic [7:0] cy);
        return {c, ax, ay, bx, by, cx, cy};
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_tri(input logic [50:0] d, input bit expect_draw);
        tri_valid = 1'b1;
        tri_data  = d;
        for (int i = 0; i < 5000; i++) begin
            if (tri_ready) begin
                tick();
                tri_valid = 1'b0;
                if (expect_draw) begin
                    exp_q.push_back({1'b0, d});
                    exp_draws++;
                end
                return;
            end
            tick();
        end
        tri_valid = 1'b0;
        check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30000; i++) begin
            tick();
            if (!busy) begin
                repeat (2) tick();
                return;
            end
        end
        check(name, 0, 1);
    endtask

    task automatic wait_drawing(input string name);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!eng_done) return;
        end
        check(name, 0, 1);
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    // Draw engine: busy for LEN cycles after a start strobe, one pixel at vertex A midway.
    initial begin
        int cnt;
        logic go;
        cnt = 0;
        forever begin
            @(negedge clock);
            go = eng_draw_en;
            @(posedge clock);
            #1;
            if (!resetn) begin
                cnt = 0; eng_done = 1'b1; eng_plot = 1'b0;
            end else if (go) begin
                eng_done = 1'b0;
                cnt = LEN;
            end else if (cnt > 0) begin
                cnt--;
                eng_plot = (cnt == LEN / 2);
                if (eng_plot) begin
                    eng_x = eng_data[47:40]; eng_y = eng_data[39:32]; eng_colour = eng_data[50:48];
                end
                if (cnt == 0) eng_done = 1'b1;
            end
        end
    end

    // Monitor: pops expected draws/clears as the DUT presents them.
    initial begin
        bit in_clear;
        int n, clr_err;
        logic [7:0] cx, cy, lx, ly;
        ev_t ev;
        in_clear = 0; n = 0; clr_err = 0; cx = 0; cy = 0; lx = 0; ly = 0;
        forever begin
            @(negedge clock);
            if (eng_draw_en) begin
                if (exp_q.size() == 0 || exp_q[0].is_clear) begin
                    check("unexpected_draw", 64'(eng_data), -1);
                end else begin
                    ev = exp_q.pop_front();
                    check("draw_data", 64'(eng_data), 64'(ev.data));
                    cur_data = ev.data;
                end
            end
            if (!eng_done && eng_data !== cur_data) hold_err++;
            if (vga_plot && eng_plot) begin
                px_cnt++;
                check("eng_pixel", 64'({vga_colour, vga_x, vga_y}),
                      64'({cur_data[50:48], cur_data[47:40], cur_data[39:32]}));
            end
            if (vga_plot && !eng_plot) begin
                if (!in_clear) begin
                    in_clear = 1; n = 0; clr_err = 0; cx = 0; cy = 0;
                    if (exp_q.size() == 0 || !exp_q[0].is_clear) check("unexpected_clear", 1, 0);
                    else void'(exp_q.pop_front());
                end
                if (vga_x !== cx || vga_y !== cy || vga_colour !== 3'b000) clr_err++;
                lx = vga_x; ly = vga_y;
                n++;
                if (cx == 8'(W - 1)) begin cx = 0; cy = cy + 8'd1; end
                else cx = cx + 8'd1;
            end else if (in_clear) begin
                in_clear = 0;
                check("clear_pixel_seq", clr_err, 0);
                if (abort_clear) begin
                    check("clear_len_aborted", n, abort_n);
                    abort_clear = 0;
                end else begin
                    check("clear_len", n, W * H);
                    check("clear_last_px", 64'({lx, ly}), 64'({8'd159, 8'd119}));
                end
            end
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        logic [50:0] t;
        bit found;
        repeat (3) tick();
        check("rst_tri_ready", tri_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_draw_en", eng_draw_en, 0);
        check("rst_vga", 64'({vga_plot, vga_x, vga_y, vga_colour}), 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_eng_data", 64'(eng_data), 0);
        resetn = 1'b1;
        tick();

        // Single triangle latency.
        t = mk(3'b100, 8'd10, 8'd10, 8'd50, 8'd10, 8'd10, 8'd50);
        tri_valid = 1'b1; tri_data = t;
        exp_q.push_back({1'b0, t}); exp_draws++;
        tick();
        tri_valid = 1'b0;
        check("t1_draw_en_t1", eng_draw_en, 0);
        tick();
        check("t1_draw_en_t2", eng_draw_en, 1);
        wait_idle("t1_idle_timeout");
        check("t1_frame_done", fd_cnt, 1);

        // FIFO fill while the engine is busy.
        push_tri(mk(3'b001, 8'd1, 8'd2, 8'd30, 8'd4, 8'd5, 8'd40), 1);
        wait_drawing("t2_draw_timeout");
        push_tri(mk(3'b010, 8'd11, 8'd12, 8'd31, 8'd14, 8'd15, 8'd41), 1);
        push_tri(mk(3'b011, 8'd21, 8'd22, 8'd32, 8'd24, 8'd25, 8'd42), 1);
        push_tri(mk(3'b101, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd43), 1);
        push_tri(mk(3'b110, 8'd41, 8'd42, 8'd34, 8'd44, 8'd45, 8'd44), 1);
        check("t2_full_ready", tri_ready, 0);
        check("t2_busy", busy, 1);
        push_tri(mk(3'b111, 8'd51, 8'd52, 8'd35, 8'd54, 8'd55, 8'd45), 1);
        wait_idle("t2_idle_timeout");
        check("t2_frame_done", fd_cnt, 2);

        // Coalesced clear requests during a draw.
        push_tri(mk(3'b010, 8'd100, 8'd100, 8'd140, 8'd100, 8'd100, 8'd110), 1);
        wait_drawing("t3_draw_timeout");
        pulse_clear();
        exp_q.push_back({1'b1, 51'd0});
        tick();
        pulse_clear();
        tick();
        pulse_clear();
        wait_idle("t3_idle_timeout");
        check("t3_frame_done", fd_cnt, 3);

        // Clear and push in the same cycle: clear first.
        t = mk(3'b011, 8'd7, 8'd8, 8'd70, 8'd8, 8'd7, 8'd80);
        clear_req = 1'b1; tri_valid = 1'b1; tri_data = t;
        exp_q.push_back({1'b1, 51'd0});
        exp_q.push_back({1'b0, t}); exp_draws++;
        tick();
        clear_req = 1'b0; tri_valid = 1'b0;
        wait_idle("t4_idle_timeout");
        check("t4_frame_done", fd_cnt, 4);

        // Reset in the middle of a clear with triangles queued.
        abort_clear = 1;
        abort_n = 60 * W + 80 + 1;
        pulse_clear();
        exp_q.push_back({1'b1, 51'd0});
        push_tri(mk(3'b001, 8'd3, 8'd3, 8'd90, 8'd3, 8'd3, 8'd90), 0);
        push_tri(mk(3'b110, 8'd4, 8'd4, 8'd91, 8'd4, 8'd4, 8'd91), 0);
        found = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            tick();
            if (vga_plot && vga_x == 8'd80 && vga_y == 8'd60) found = 1;
        end
        check("t5_reach_80_60", found, 1);
        resetn = 1'b0;
        #1;
        check("t5_rst_vga_plot", vga_plot, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_tri_ready", tri_ready, 1);
        check("t5_rst_draw_en", eng_draw_en, 0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (40) tick();
        check("t5_post_busy", busy, 0);
        check("t5_queue_empty", exp_q.size(), 0);

        // Collinear triangle followed by a real one.
`ifdef TRI_SCHED_CULL_EN
        push_tri(mk(3'b101, 8'd0, 8'd0, 8'd5, 8'd5, 8'd10, 8'd10), 0);
`else
        push_tri(mk(3'b101, 8'd0, 8'd0, 8'd5, 8'd5, 8'd10, 8'd10), 1);
`endif
        push_tri(mk(3'b100, 8'd20, 8'd20, 8'd60, 8'd20, 8'd20, 8'd70), 1);
        wait_idle("t6_idle_timeout");
        check("t6_frame_done", fd_cnt, 5);

        check("hold_eng_data", hold_err, 0);
        check("final_queue_empty", exp_q.size(), 0);
        check("eng_pixel_count", px_cnt, exp_draws);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/triangle_scheduler.md
# triangle_scheduler

Command front-end for the triangle rasteriser: buffers incoming triangle commands in a small FIFO, issues them one at a time to the triangle draw engine using its enable/done handshake, and interleaves full-screen clears. It owns the pixel-write port toward the VGA adapter, muxing between its own clear sweep and the engine's plot stream.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- SCREEN_W, 160, clear sweep width in pixels
- SCREEN_H, 120, clear sweep height in pixels
- CLEAR_COLOUR, 3'b000, colour written during clear

- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset; also drives the engine's resetn
- tri_valid  in  1  triangle command offered
- tri_ready  out  1  FIFO can accept (= !full)
- tri_data  in  51  {colour[50:48], ax[47:40], ay[39:32], bx[31:24], by[23:16], cx[15:8], cy[7:0]}
- clear_req  in  1  request a screen clear (level or pulse; sampled each cycle)
- eng_data  out  51  current triangle to engine, same packing; registered, held stable while drawing
- eng_draw_en  out  1  one-cycle start strobe to engine
- eng_done  in  1  engine idle (high while engine waits)
- eng_x, eng_y  in  8  engine pixel coordinate
- eng_colour  in  3  engine pixel colour
- eng_plot  in  1  engine pixel write
- vga_x, vga_y  out  8  pixel coordinate to VGA adapter
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write strobe
- busy  out  1  state != IDLE, FIFO non-empty, or clear pending
- frame_done  out  1  one-cycle pulse when all work drains

## Operation
- States: IDLE, CLEAR, ISSUE, ARM, DRAW.
- FIFO push when tri_valid & tri_ready. No fall-through; pop only in IDLE. Full FIFO: tri_ready=0, offered command held off.
- clear_pending set on clear_req; repeated requests while pending coalesce into one clear. Cleared on entry to CLEAR.
- IDLE: if clear_pending → CLEAR (clear has priority over queued triangles). Else if FIFO non-empty → pop head into eng_data, → ISSUE. Else stay.
- CLEAR: sweep x 0..SCREEN_W-1 fastest, then y 0..SCREEN_H-1; vga_plot=1, vga_colour=CLEAR_COLOUR every cycle; after (SCREEN_W-1, SCREEN_H-1) → IDLE. Never preempts a triangle in progress; clear_req during DRAW waits.
- ISSUE: if eng_done=1, assert eng_draw_en, → ARM; else wait.
- ARM: one cycle for engine to leave its wait state; → DRAW.
- DRAW: wait for eng_done=1, → IDLE.
- vga_* = clear sweep in CLEAR; otherwise eng_x/eng_y/eng_colour pass-through with vga_plot = eng_plot & (state==DRAW).
- frame_done pulses in the cycle CLEAR or DRAW exits to IDLE with FIFO empty, no push that cycle, and clear_pending=0.
- Pushes accepted in every state, including CLEAR and DRAW.

## Timing
- Reset (asynchronous, immediate): state=IDLE, FIFO empty, clear_pending=0, eng_data=0, eng_draw_en=0, vga_plot=0, vga_x=vga_y=0, vga_colour=0, frame_done=0, busy=0, tri_ready=1.
- Push at cycle t → IDLE pops at t+1 → eng_draw_en high at t+2 → engine drawing from t+3.
- Back-to-back triangles: DRAW→IDLE→ISSUE→ARM; 3 idle cycles between engine draws.
- Clear takes exactly SCREEN_W*SCREEN_H cycles of vga_plot=1 (19200 at defaults).
- Reset mid-draw or mid-clear: all queued and pending work discarded; engine reset by same resetn.
- Simultaneous push and pop when full is impossible (ready low); when non-full, both occur and count is unchanged.

## Configuration
- TRI_SCHED_CULL_EN defined: in IDLE, a popped triangle with zero signed area ((bx-ax)*(cy-ay) − (by-ay)*(cx-ax) == 0, 17-bit signed operands) is discarded; state stays IDLE, no eng_draw_en, one cycle consumed.
- Undefined: every triangle is issued to the engine regardless of area.

## Test plan
- Reset then push one triangle (10,10),(50,10),(10,50) colour 3'b100 at t → eng_draw_en at t+2, eng_data held until eng_done returns, frame_done one pulse after.
- Push 5 triangles back-to-back with DEPTH=4 while engine busy → tri_ready low after 4th stored, all 5 drawn in order, none lost.
- clear_req asserted 3 times during a draw → exactly one clear after draw completes; 19200 plots, first (0,0), last (159,119), colour 3'b000.
- clear_req and a triangle push in same cycle from IDLE → CLEAR runs first, triangle drawn after.
- Assert resetn low mid-clear at pixel (80,60) → vga_plot 0 immediately, busy 0, tri_ready 1, queued triangles gone.
- With TRI_SCHED_CULL_EN: push collinear (0,0),(5,5),(10,10) then a valid triangle → no eng_draw_en for first, second issued; without macro both issued.
